// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sine generator: default widths,
// quadrant codes and the sample sequencer state encoding.
package cordic_pkg;

   localparam int W_DEF     = 20;
   localparam int ACC_W_DEF = 32;

   localparam logic [2:0] Q1 = 3'd1;
   localparam logic [2:0] Q2 = 3'd2;
   localparam logic [2:0] Q3 = 3'd3;
   localparam logic [2:0] Q4 = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_MAP    = 3'd3,
      ST_HOLD   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/cordic_quadrant_unmap.sv
// Combinational quadrant un-mapping of a CORDIC result back to the full
// circle; negations saturate so the most negative value never wraps.
module cordic_quadrant_unmap
   import cordic_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [2:0]   quad,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] cos_val,
   output logic [W-1:0] sin_val
);

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

   function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
      if (v == MOST_NEG) return MOST_POS;
      return -v;
   endfunction

   always_comb begin
      cos_val = x;
      sin_val = y;
      case (quad)
         Q2: begin
            cos_val = sat_neg(y);
            sin_val = x;
         end
         Q3: begin
            cos_val = sat_neg(x);
            sin_val = sat_neg(y);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cordic_sample_sequencer.sv
// Phase accumulator and sample sequencer for the CORDIC sine generator:
// reduces phase, drives the rotation core, un-maps and streams cos/sin.
module cordic_sample_sequencer
   import cordic_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [ACC_W-1:0] fcw,
   output logic             core_start,
   output logic [W-1:0]     core_angle,
   input  logic             core_done,
   input  logic [W-1:0]     core_x,
   input  logic [W-1:0]     core_y,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic [W-1:0]     sample_cos,
   output logic [W-1:0]     sample_sin,
   output logic [2:0]       sample_quad,
   output logic             err_timeout,
   output logic [2:0]       dbg_state
);

   // Stream handshake: a sample transfers on a rising edge where
   // sample_valid and sample_ready are both high; until then every sample
   // output is frozen, and sample_valid never drops without a transfer.

   localparam int              CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   seq_state_t       state, state_nxt;
   logic [ACC_W-1:0] acc;
   logic [W-1:0]     phase;
   logic [2:0]       quad_r;
   logic [W-1:0]     x_r, y_r;
   logic [W-1:0]     map_cos, map_sin;
   logic [CNT_W-1:0] cnt;

   assign phase     = acc[ACC_W-1 -: W];
   assign dbg_state = state;

   cordic_quadrant_unmap #(.W(W)) u_unmap (
      .quad    (quad_r),
      .x       (x_r),
      .y       (y_r),
      .cos_val (map_cos),
      .sin_val (map_sin)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      core_start   = 1'b0;
      sample_valid = 1'b0;
      case (state)
         ST_IDLE:   if (en) state_nxt = ST_LAUNCH;
         ST_LAUNCH: begin
            core_start = 1'b1;
            state_nxt  = ST_WAIT;
         end
         // A done arriving on the expiry cycle still completes the sample.
         ST_WAIT: begin
            if (core_done)           state_nxt = ST_MAP;
            else if (cnt == CNT_MAX) state_nxt = ST_IDLE;
         end
         ST_MAP:    state_nxt = ST_HOLD;
         ST_HOLD: begin
            sample_valid = 1'b1;
            if (sample_ready) state_nxt = ST_IDLE;
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         core_angle  <= '0;
         quad_r      <= Q1;
         x_r         <= '0;
         y_r         <= '0;
         cnt         <= '0;
         sample_cos  <= '0;
         sample_sin  <= '0;
         sample_quad <= Q1;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (en) begin
                  // Fourth quadrant maps to the equivalent negative angle.
                  core_angle <= (phase[W-1:W-2] == 2'b11) ? {2'b11, phase[W-3:0]}
                                                          : {2'b00, phase[W-3:0]};
                  quad_r     <= {1'b0, phase[W-1:W-2]} + 3'd1;
               end
            end
            ST_LAUNCH: cnt <= '0;
            ST_WAIT: begin
               if (core_done) begin
                  x_r <= core_x;
                  y_r <= core_y;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_MAX) err_timeout <= 1'b1;
               end
            end
            ST_MAP: begin
               sample_cos  <= map_cos;
               sample_sin  <= map_sin;
               sample_quad <= quad_r;
            end
            ST_HOLD: if (sample_ready) acc <= acc + fcw;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_sample_sequencer.sv
// Self-checking bench for cordic_sample_sequencer: behavioural core model,
// expected-result scoreboard and a separate short-timeout instance.
module tb_cordic_sample_sequencer;

   localparam int W        = 20;
   localparam int ACC_W    = 32;
   localparam int CORE_LAT = 18;
   localparam int T_TO     = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- main instance ----------------
   logic             rst, en, sample_ready;
   logic [ACC_W-1:0] fcw;
   logic             core_start, core_done, sample_valid, err_timeout;
   logic [W-1:0]     core_angle, core_x, core_y, sample_cos, sample_sin;
   logic [2:0]       sample_quad, dbg_state;

   cordic_sample_sequencer #(.W(W), .ACC_W(ACC_W), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .en(en), .fcw(fcw),
      .core_start(core_start), .core_angle(core_angle), .core_done(core_done),
      .core_x(core_x), .core_y(core_y),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sample_cos(sample_cos), .sample_sin(sample_sin), .sample_quad(sample_quad),
      .err_timeout(err_timeout), .dbg_state(dbg_state)
   );

   // ---------------- short-timeout instance ----------------
   logic             t_rst, t_en, t_ready, t_start, t_done, t_valid, t_err;
   logic [ACC_W-1:0] t_fcw;
   logic [W-1:0]     t_angle, t_x, t_y, t_cos, t_sin;
   logic [2:0]       t_quad, t_state;

   cordic_sample_sequencer #(.W(W), .ACC_W(ACC_W), .TIMEOUT(T_TO)) t_dut (
      .clk(clk), .rst(t_rst), .en(t_en), .fcw(t_fcw),
      .core_start(t_start), .core_angle(t_angle), .core_done(t_done),
      .core_x(t_x), .core_y(t_y),
      .sample_valid(t_valid), .sample_ready(t_ready),
      .sample_cos(t_cos), .sample_sin(t_sin), .sample_quad(t_quad),
      .err_timeout(t_err), .dbg_state(t_state)
   );

   // ---------------- core model ----------------
   // Start seen at edge s; done is driven after edge s+CORE_LAT.
   logic         force_en = 1'b0;
   logic [W-1:0] force_x = '0, force_y = '0;
   logic         c_busy = 1'b0;
   int           c_cnt = 0;
   logic [W-1:0] c_ang = '0;
   int           start_cnt = 0;

   initial begin
      core_done = 1'b0;
      core_x    = '0;
      core_y    = '0;
   end

   always @(posedge clk) begin
      if (core_start) start_cnt++;
      core_done <= 1'b0;
      if (core_start) begin
         c_busy <= 1'b1;
         c_cnt  <= 0;
         c_ang  <= core_angle;
      end else if (c_busy) begin
         c_cnt <= c_cnt + 1;
         if (c_cnt == CORE_LAT - 1) begin
            core_done <= 1'b1;
            c_busy    <= 1'b0;
            core_x    <= force_en ? force_x : c_ang;
            core_y    <= force_en ? force_y : -c_ang;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int                n_vec = 0;
   int                n_err = 0;
   logic [W-1:0]      ang_q[$];
   logic [W+W+2:0]    exp_q[$];
   logic [ACC_W-1:0]  acc_m = '0;
   int                prev_start = -1;
   int                exp_period = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int neg_clip(input int v);
      int n;
      n = -v;
      if (n > 524287) n = 524287;
      return n;
   endfunction

   task automatic check_reset(input string tag);
      check_val({tag, "_valid"}, sample_valid, 1'b0);
      check_val({tag, "_start"}, core_start, 1'b0);
      check_val({tag, "_angle"}, core_angle, 20'h0);
      check_val({tag, "_cos"}, sample_cos, 20'h0);
      check_val({tag, "_sin"}, sample_sin, 20'h0);
      check_val({tag, "_quad"}, sample_quad, 3'd1);
      check_val({tag, "_err"}, err_timeout, 1'b0);
      check_val({tag, "_state"}, dbg_state, 3'd0);
      check_val({tag, "_acc"}, dut.acc, 32'h0);
   endtask

   // ---------------- driver ----------------
   // f is the fcw presented at this sample's handshake; rdly>0 holds ready low.
   task automatic run_sample(input logic [ACC_W-1:0] f, input int rdly, input bit frc,
                             input logic [W-1:0] fx, input logic [W-1:0] fy);
      logic [W-1:0]   p;
      int             q, ang, x, y, c, s, sc;
      logic [2:0]     qc;
      logic [W+W+2:0] w;
      bit             ok;
      p   = acc_m[ACC_W-1 -: W];
      q   = int'(p[W-1:W-2]);
      ang = (q == 3) ? int'(p) - 1048576 : int'(p[W-3:0]);
      x   = frc ? int'($signed(fx)) : ang;
      y   = frc ? int'($signed(fy)) : -ang;
      case (q)
         1:       begin c = neg_clip(y); s = x;           end
         2:       begin c = neg_clip(x); s = neg_clip(y); end
         default: begin c = x;           s = y;           end
      endcase
      qc = 3'(q + 1);
      ang_q.push_back(ang[W-1:0]);
      exp_q.push_back({qc, c[W-1:0], s[W-1:0]});

      force_en = frc; force_x = fx; force_y = fy;
      fcw = f; sample_ready = (rdly == 0); en = 1'b1;

      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = core_start;
      end
      if (!ok) begin
         check_val("start_seen", 1'b0, 1'b1);
         void'(ang_q.pop_front()); void'(exp_q.pop_front());
         return;
      end
      check_val("core_angle", core_angle, ang_q.pop_front());
      if (exp_period > 0 && prev_start >= 0) check_val("period", cyc - prev_start, exp_period);
      prev_start = cyc;

      ok = 1'b0;
      for (int i = 0; i < CORE_LAT + 20 && !ok; i++) begin
         @(negedge clk);
         ok = sample_valid;
      end
      w = exp_q.pop_front();
      if (!ok) begin
         check_val("valid_seen", 1'b0, 1'b1);
         return;
      end
      check_val("quad", sample_quad, w[W+W+2 -: 3]);
      check_val("cos", sample_cos, w[W+W-1 -: W]);
      check_val("sin", sample_sin, w[W-1:0]);

      if (rdly > 0) begin
         sc  = start_cnt;
         fcw = 32'hDEAD_0000;
         repeat (rdly) begin
            @(negedge clk);
            check_val("hold_valid", sample_valid, 1'b1);
            check_val("hold_cos", sample_cos, w[W+W-1 -: W]);
            check_val("hold_sin", sample_sin, w[W-1:0]);
            check_val("hold_acc", dut.acc, acc_m);
         end
         check_val("hold_no_start", start_cnt, sc);
         fcw = f;
         sample_ready = 1'b1;
      end
      @(posedge clk);
      acc_m = acc_m + f;
      @(negedge clk);
      check_val("acc_step", dut.acc, acc_m);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int  n;
      bit  ok;
      rst = 1'b1; en = 1'b0; fcw = '0; sample_ready = 1'b0;
      t_rst = 1'b1; t_en = 1'b0; t_fcw = 32'h1000_0000; t_ready = 1'b1;
      t_done = 1'b0; t_x = '0; t_y = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      rst = 1'b0; t_rst = 1'b0;

      // quarter-turn sweep, ready held high
      exp_period = CORE_LAT + 5;
      for (int k = 0; k < 4; k++) run_sample(32'h4000_0000, 0, 1'b0, '0, '0);
      exp_period = 0;

      // quadrant boundaries: p = 0x3FFFF, 0x40000, 0xC0000
      run_sample(32'h3FFF_F000, 0, 1'b0, '0, '0);
      run_sample(32'h0000_1000, 0, 1'b0, '0, '0);
      run_sample(32'h8000_0000, 0, 1'b0, '0, '0);
      run_sample(32'hC000_0000, 0, 1'b0, '0, '0);

      // saturation in Q3 then Q2
      run_sample(32'hC000_0000, 0, 1'b1, 20'h80000, 20'd5);
      run_sample(32'h1234_5000, 0, 1'b1, 20'd7, 20'h80000);

      // backpressure
      run_sample(32'h0ABC_D000, 10, 1'b0, '0, '0);

      // reset in the middle of WAIT, late done afterwards
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = core_start;
      end
      check_val("abort_start", ok, 1'b1);
      en = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("midrst");
      repeat (CORE_LAT + 5) @(negedge clk);
      check_val("late_done_state", dbg_state, 3'd0);
      check_val("late_done_valid", sample_valid, 1'b0);
      acc_m = '0;
      prev_start = -1;
      run_sample(32'h0000_5000, 0, 1'b0, '0, '0);
      run_sample(32'h0000_0000, 0, 1'b0, '0, '0);
      en = 1'b0;

      // timeout with a silent core
      @(negedge clk);
      check_val("to_reset_err", t_err, 1'b0);
      t_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = t_start;
      end
      check_val("to_start", ok, 1'b1);
      t_en = 1'b0;
      n = 0; ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         n++;
         ok = t_err;
      end
      check_val("to_edges", n, T_TO + 1);
      check_val("to_state", t_state, 3'd0);
      check_val("to_valid", t_valid, 1'b0);
      check_val("to_acc", t_dut.acc, 32'h0);
      repeat (3) @(posedge clk); #1;
      check_val("to_sticky", t_err, 1'b1);

      // done arriving in the last WAIT cycle
      @(negedge clk); t_rst = 1'b1;
      @(negedge clk); t_rst = 1'b0;
      check_val("to2_err_clr", t_err, 1'b0);
      t_en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = t_start;
      end
      check_val("to2_start", ok, 1'b1);
      t_en = 1'b0;
      repeat (T_TO) @(posedge clk);
      #1;
      t_done = 1'b1; t_x = 20'd1234; t_y = 20'hFFF9D;
      @(posedge clk); #1;
      t_done = 1'b0;
      check_val("to2_err", t_err, 1'b0);
      check_val("to2_state", t_state, 3'd3);
      ok = 1'b0;
      for (int i = 0; i < 5 && !ok; i++) begin
         @(negedge clk);
         ok = t_valid;
      end
      check_val("to2_valid", ok, 1'b1);
      check_val("to2_cos", t_cos, 20'd1234);
      check_val("to2_sin", t_sin, 20'hFFF9D);
      check_val("to2_quad", t_quad, 3'd1);
      @(negedge clk);
      check_val("to2_acc", t_dut.acc, 32'h1000_0000);
      check_val("to2_err_end", t_err, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
